// File: rtl/calc_pkg.sv
// Shared definitions for the calculator control path.
//   state_t  : sequencer state encoding (ENTER_A..ERR, 3-bit)
//   KEY_*    : keypad codes with a control meaning (digits are 0-9)
//   OP_*     : o_ADDSUB encoding
package calc_pkg;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_EXEC    = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERR     = 3'd4
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CE  = 4'hF;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

  function automatic logic is_op(input logic [3:0] k);
    return (k == KEY_ADD) || (k == KEY_SUB);
  endfunction

  function automatic logic op_of(input logic [3:0] k);
    return (k == KEY_SUB) ? OP_SUB : OP_ADD;
  endfunction

endpackage

// File: rtl/key_event_buffer.sv
// One-entry pending-key register.
//   clk, rst_n   : clock, synchronous active-low reset
//   wr_en/wr_key : store a key (overwrites any held key)
//   rd_en        : consume the held key
//   rd_discard   : the consumer used a different key; a held key is lost
//   pend_valid/pend_key : held entry
//   drop         : registered one-cycle pulse when a held key is lost
module key_event_buffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  logic [3:0] wr_key,
  input  logic       rd_en,
  input  logic       rd_discard,
  output logic       pend_valid,
  output logic [3:0] pend_key,
  output logic       drop
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_key   <= '0;
      drop       <= 1'b0;
    end else begin
      drop <= 1'b0;
      if (wr_en) begin
        pend_valid <= 1'b1;
        pend_key   <= wr_key;
        drop       <= pend_valid;
      end else if (rd_en) begin
        pend_valid <= 1'b0;
        drop       <= rd_discard & pend_valid;
      end
    end
  end

endmodule

// File: rtl/calc_op_sequencer.sv
// Keypad-driven sequencer for the calculator datapath.
//   i_CLOCK, i_RESET_N : clock, synchronous active-low reset
//   i_TRIG, i_KEY      : one-cycle key event and its code
//   i_ENTRY_VALID      : current IU entry fits in 8-bit two's complement
//   i_GAME             : game mode owns the displays; sequencer frozen
//   o_LOADA_N/o_LOADB_N: active-low one-cycle operand load strobes
//   o_LOADR            : AU result enable, EXEC_CYCLES cycles per execution
//   o_ADDSUB           : held operator (0 add, 1 subtract)
//   o_SRC_R            : A-mux takes the AU result (chain load)
//   o_CLR_ENTRY        : one-cycle IU entry clear
//   o_IUAU             : display select (0 IU, 1 AU)
//   o_ERR, o_DROP      : error indicator, pending-key-lost pulse
//   o_STATE            : current state encoding
// All outputs are registered: a key sampled at an edge shows its effect
// in the cycle that follows that edge.
import calc_pkg::*;

module calc_op_sequencer #(
  parameter int unsigned EXEC_CYCLES = 2
) (
  input  logic       i_CLOCK,
  input  logic       i_RESET_N,
  input  logic       i_TRIG,
  input  logic [3:0] i_KEY,
  input  logic       i_ENTRY_VALID,
  input  logic       i_GAME,
  output logic       o_LOADA_N,
  output logic       o_LOADB_N,
  output logic       o_LOADR,
  output logic       o_ADDSUB,
  output logic       o_SRC_R,
  output logic       o_CLR_ENTRY,
  output logic       o_IUAU,
  output logic       o_ERR,
  output logic       o_DROP,
  output logic [2:0] o_STATE
);

  localparam logic [3:0] EXEC_LAST   = 4'(EXEC_CYCLES);
  localparam logic [3:0] EXEC_PENULT = 4'(EXEC_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       digit_seen_q, digit_seen_d;
  logic       loada_n_q, loada_n_d;
  logic       loadb_n_q, loadb_n_d;
  logic       loadr_q, loadr_d;
  logic       addsub_q, addsub_d;
  logic       src_r_q, src_r_d;
  logic       clr_q, clr_d;
  logic       iuau_q, iuau_d;
  logic       err_q, err_d;

  logic       live;
  logic       pend_valid;
  logic [3:0] pend_key;
  logic       pend_use;
  logic       key_evt;
  logic [3:0] key;

  // A pending key only ever exists on the first SHOW cycle (it is filled in
  // EXEC and consumed here), so no separate first-cycle flag is needed.
  // A live key in that cycle wins and the pending one is discarded.
  assign live     = i_TRIG & ~i_GAME;
  assign pend_use = pend_valid & (state_q == ST_SHOW) & ~i_GAME;
  assign key_evt  = live | pend_use;
  assign key      = live ? i_KEY : pend_key;

  key_event_buffer u_key_buf (
    .clk        (i_CLOCK),
    .rst_n      (i_RESET_N),
    .wr_en      (live & (state_q == ST_EXEC)),
    .wr_key     (i_KEY),
    .rd_en      (pend_use),
    .rd_discard (live),
    .pend_valid (pend_valid),
    .pend_key   (pend_key),
    .drop       (o_DROP)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    digit_seen_d = digit_seen_q;
    loada_n_d    = 1'b1;
    loadb_n_d    = 1'b1;
    loadr_d      = 1'b0;
    addsub_d     = addsub_q;
    src_r_d      = 1'b0;
    clr_d        = 1'b0;
    iuau_d       = iuau_q;
    err_d        = err_q;

    if (!i_GAME) begin
      case (state_q)
        ST_ENTER_A: begin
          if (key_evt) begin
            if (is_op(key)) begin
              if (i_ENTRY_VALID) begin
                loada_n_d    = 1'b0;
                addsub_d     = op_of(key);
                clr_d        = 1'b1;
                digit_seen_d = 1'b0;
                state_d      = ST_ENTER_B;
              end else begin
                err_d   = 1'b1;
                state_d = ST_ERR;
              end
            end else if (key == KEY_CE) begin
              clr_d = 1'b1;
            end
          end
        end

        ST_ENTER_B: begin
          if (key_evt) begin
            if (is_digit(key)) begin
              digit_seen_d = 1'b1;
            end else if (is_op(key)) begin
              addsub_d = op_of(key);
            end else if (key == KEY_EQ) begin
              if (digit_seen_q) begin
                if (i_ENTRY_VALID) begin
                  loadb_n_d = 1'b0;
                  cnt_d     = '0;
                  state_d   = ST_EXEC;
                end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERR;
                end
              end
            end else if (key == KEY_CE) begin
              clr_d        = 1'b1;
              digit_seen_d = 1'b0;
            end
          end
        end

        // First EXEC cycle carries the B strobe; o_LOADR follows for
        // EXEC_CYCLES cycles, then one more edge moves to SHOW.
        ST_EXEC: begin
          if (cnt_q == EXEC_LAST) begin
            cnt_d   = '0;
            iuau_d  = 1'b1;
            state_d = ST_SHOW;
          end else begin
            loadr_d = 1'b1;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == EXEC_PENULT) clr_d = 1'b1;
          end
        end

        ST_SHOW: begin
          if (key_evt) begin
            if (is_digit(key)) begin
              iuau_d  = 1'b0;
              state_d = ST_ENTER_A;
            end else if (is_op(key)) begin
              loada_n_d    = 1'b0;
              src_r_d      = 1'b1;
              addsub_d     = op_of(key);
              clr_d        = 1'b1;
              digit_seen_d = 1'b0;
              state_d      = ST_ENTER_B;
            end else if (key == KEY_CE) begin
              iuau_d  = 1'b0;
              clr_d   = 1'b1;
              state_d = ST_ENTER_A;
            end
          end
        end

        ST_ERR: begin
          if (key_evt && (key == KEY_CE)) begin
            clr_d   = 1'b1;
            err_d   = 1'b0;
            state_d = ST_ENTER_A;
          end
        end

        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  always_ff @(posedge i_CLOCK) begin
    if (!i_RESET_N) begin
      state_q      <= ST_ENTER_A;
      cnt_q        <= '0;
      digit_seen_q <= 1'b0;
      loada_n_q    <= 1'b1;
      loadb_n_q    <= 1'b1;
      loadr_q      <= 1'b0;
      addsub_q     <= 1'b0;
      src_r_q      <= 1'b0;
      clr_q        <= 1'b0;
      iuau_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      digit_seen_q <= digit_seen_d;
      loada_n_q    <= loada_n_d;
      loadb_n_q    <= loadb_n_d;
      loadr_q      <= loadr_d;
      addsub_q     <= addsub_d;
      src_r_q      <= src_r_d;
      clr_q        <= clr_d;
      iuau_q       <= iuau_d;
      err_q        <= err_d;
    end
  end

  assign o_LOADA_N   = loada_n_q;
  assign o_LOADB_N   = loadb_n_q;
  assign o_LOADR     = loadr_q;
  assign o_ADDSUB    = addsub_q;
  assign o_SRC_R     = src_r_q;
  assign o_CLR_ENTRY = clr_q;
  assign o_IUAU      = iuau_q;
  assign o_ERR       = err_q;
  assign o_STATE     = state_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with EXEC_CYCLES = 2.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same
// point, so each check sees the registers updated by the preceding edge.
module tb_calc_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [3:0] key = 4'h0;
  logic       entry_valid = 1'b1;
  logic       game = 1'b0;
  logic       loada_n, loadb_n, loadr, addsub, src_r, clr, iuau, err, drop;
  logic [2:0] state;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  calc_op_sequencer #(.EXEC_CYCLES(2)) dut (
    .i_CLOCK       (clk),
    .i_RESET_N     (rst_n),
    .i_TRIG        (trig),
    .i_KEY         (key),
    .i_ENTRY_VALID (entry_valid),
    .i_GAME        (game),
    .o_LOADA_N     (loada_n),
    .o_LOADB_N     (loadb_n),
    .o_LOADR       (loadr),
    .o_ADDSUB      (addsub),
    .o_SRC_R       (src_r),
    .o_CLR_ENTRY   (clr),
    .o_IUAU        (iuau),
    .o_ERR         (err),
    .o_DROP        (drop),
    .o_STATE       (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] k);
    trig = 1'b1;
    key  = k;
    tick();
    trig = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 8'(state), 8'd0);
    chk({tag, "_loada"}, 8'(loada_n), 8'd1);
    chk({tag, "_loadb"}, 8'(loadb_n), 8'd1);
    chk({tag, "_loadr"}, 8'(loadr), 8'd0);
    chk({tag, "_addsub"}, 8'(addsub), 8'd0);
    chk({tag, "_srcr"}, 8'(src_r), 8'd0);
    chk({tag, "_clr"}, 8'(clr), 8'd0);
    chk({tag, "_iuau"}, 8'(iuau), 8'd0);
    chk({tag, "_err"}, 8'(err), 8'd0);
    chk({tag, "_drop"}, 8'(drop), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset
    tick();
    tick();
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // basic 5 + 3 =
    press(4'h5);
    chk("digitA_state", 8'(state), 8'd0);
    chk("digitA_clr", 8'(clr), 8'd0);
    press(4'hA);
    chk("opA_loada", 8'(loada_n), 8'd0);
    chk("opA_addsub", 8'(addsub), 8'd0);
    chk("opA_clr", 8'(clr), 8'd1);
    chk("opA_srcr", 8'(src_r), 8'd0);
    chk("opA_state", 8'(state), 8'd1);
    tick();
    chk("opA_loada_end", 8'(loada_n), 8'd1);
    chk("opA_clr_end", 8'(clr), 8'd0);
    press(4'h3);
    chk("digitB_loadb", 8'(loadb_n), 8'd1);
    press(4'hE);
    chk("eq_loadb", 8'(loadb_n), 8'd0);
    chk("eq_state", 8'(state), 8'd2);
    chk("eq_loadr", 8'(loadr), 8'd0);
    tick();
    chk("ex1_loadb", 8'(loadb_n), 8'd1);
    chk("ex1_loadr", 8'(loadr), 8'd1);
    chk("ex1_clr", 8'(clr), 8'd0);
    tick();
    chk("ex2_loadr", 8'(loadr), 8'd1);
    chk("ex2_clr", 8'(clr), 8'd1);
    tick();
    chk("show_loadr", 8'(loadr), 8'd0);
    chk("show_clr", 8'(clr), 8'd0);
    chk("show_state", 8'(state), 8'd3);
    chk("show_iuau", 8'(iuau), 8'd1);

    // chain from SHOW with subtract
    press(4'hB);
    chk("chain_loada", 8'(loada_n), 8'd0);
    chk("chain_srcr", 8'(src_r), 8'd1);
    chk("chain_addsub", 8'(addsub), 8'd1);
    chk("chain_state", 8'(state), 8'd1);
    chk("chain_clr", 8'(clr), 8'd1);
    tick();
    chk("chain_loada_end", 8'(loada_n), 8'd1);
    chk("chain_srcr_end", 8'(src_r), 8'd0);

    // E without a digit is ignored; operator replacement
    press(4'hE);
    chk("eq_nodigit_loadb", 8'(loadb_n), 8'd1);
    chk("eq_nodigit_state", 8'(state), 8'd1);
    press(4'hB);
    chk("repl_b_addsub", 8'(addsub), 8'd1);
    press(4'hA);
    chk("repl_a_addsub", 8'(addsub), 8'd0);
    chk("repl_a_loada", 8'(loada_n), 8'd1);
    press(4'h4);
    press(4'hE);
    chk("eq2_loadb", 8'(loadb_n), 8'd0);
    chk("eq2_state", 8'(state), 8'd2);

    // two keys during EXEC: overwrite drops the first
    press(4'h7);
    chk("pend1_loadr", 8'(loadr), 8'd1);
    chk("pend1_addsub", 8'(addsub), 8'd0);
    chk("pend1_drop", 8'(drop), 8'd0);
    press(4'hA);
    chk("pend2_drop", 8'(drop), 8'd1);
    chk("pend2_loadr", 8'(loadr), 8'd1);
    tick();
    chk("pend_show_state", 8'(state), 8'd3);
    chk("pend_show_drop", 8'(drop), 8'd0);
    chk("pend_show_loadr", 8'(loadr), 8'd0);
    tick();
    chk("pend_chain_loada", 8'(loada_n), 8'd0);
    chk("pend_chain_srcr", 8'(src_r), 8'd1);
    chk("pend_chain_addsub", 8'(addsub), 8'd0);
    chk("pend_chain_state", 8'(state), 8'd1);

    // error from ENTER_B
    entry_valid = 1'b0;
    press(4'h5);
    press(4'hE);
    chk("errB_state", 8'(state), 8'd4);
    chk("errB_err", 8'(err), 8'd1);
    chk("errB_loadb", 8'(loadb_n), 8'd1);
    entry_valid = 1'b1;
    press(4'hA);
    chk("err_ign_a", 8'(state), 8'd4);
    press(4'hE);
    chk("err_ign_e", 8'(state), 8'd4);
    press(4'h5);
    chk("err_ign_5", 8'(state), 8'd4);
    chk("err_ign_err", 8'(err), 8'd1);
    chk("err_ign_clr", 8'(clr), 8'd0);
    press(4'hF);
    chk("err_exit_clr", 8'(clr), 8'd1);
    chk("err_exit_state", 8'(state), 8'd0);
    chk("err_exit_err", 8'(err), 8'd0);

    // error from ENTER_A
    entry_valid = 1'b0;
    press(4'hB);
    chk("errA_state", 8'(state), 8'd4);
    chk("errA_loada", 8'(loada_n), 8'd1);
    entry_valid = 1'b1;
    press(4'hF);
    chk("errA_exit_state", 8'(state), 8'd0);

    // game mode freezes EXEC mid-way
    press(4'hA);
    press(4'h2);
    press(4'hE);
    chk("g_eq_state", 8'(state), 8'd2);
    tick();
    chk("g_ex1_loadr", 8'(loadr), 8'd1);
    game = 1'b1;
    tick();
    chk("g_frz_loadr", 8'(loadr), 8'd0);
    chk("g_frz_state", 8'(state), 8'd2);
    trig = 1'b1;
    key  = 4'h7;
    for (int i = 0; i < 9; i++) tick();
    trig = 1'b0;
    chk("g_hold_loadr", 8'(loadr), 8'd0);
    chk("g_hold_clr", 8'(clr), 8'd0);
    chk("g_hold_state", 8'(state), 8'd2);
    game = 1'b0;
    tick();
    chk("g_res_loadr", 8'(loadr), 8'd1);
    chk("g_res_clr", 8'(clr), 8'd1);
    chk("g_res_drop", 8'(drop), 8'd0);
    tick();
    chk("g_show_state", 8'(state), 8'd3);
    chk("g_show_loadr", 8'(loadr), 8'd0);
    tick();
    chk("g_nopend_state", 8'(state), 8'd3);
    chk("g_nopend_loada", 8'(loada_n), 8'd1);

    // live key beats pending key on the first SHOW cycle
    press(4'hF);
    chk("ce_show_iuau", 8'(iuau), 8'd0);
    chk("ce_show_state", 8'(state), 8'd0);
    chk("ce_show_clr", 8'(clr), 8'd1);
    press(4'hA);
    press(4'h1);
    press(4'hE);
    tick();
    press(4'h7);
    chk("prio_fill_drop", 8'(drop), 8'd0);
    tick();
    chk("prio_show_state", 8'(state), 8'd3);
    press(4'hB);
    chk("prio_loada", 8'(loada_n), 8'd0);
    chk("prio_srcr", 8'(src_r), 8'd1);
    chk("prio_addsub", 8'(addsub), 8'd1);
    chk("prio_state", 8'(state), 8'd1);
    chk("prio_drop", 8'(drop), 8'd1);

    // reset mid-EXEC
    press(4'h3);
    press(4'hE);
    tick();
    chk("mid_loadr", 8'(loadr), 8'd1);
    rst_n = 1'b0;
    tick();
    chk_reset_vals("mid_rst");
    rst_n = 1'b1;
    tick();
    chk("post_rst_state", 8'(state), 8'd0);
    chk("post_rst_loadr", 8'(loadr), 8'd0);
    press(4'hE);
    chk("post_rst_eq_state", 8'(state), 8'd0);
    chk("post_rst_eq_loadb", 8'(loadb_n), 8'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/calc_op_sequencer.md
# calc_op_sequencer

Keypad-driven sequencer for the calculator datapath. Consumes one-cycle key events from the keypad input unit and issues load strobes to the arithmetic unit (A, B, result), the add/subtract select, the entry-clear pulse and the IU/AU display select. It also holds a one-entry pending-key buffer so that a key arriving during execution is not lost. It sits between the keypad input unit and the arithmetic/output units, and freezes while the game mode owns the displays.

## Interface
- EXEC_CYCLES, default 2: number of cycles `o_LOADR` is held high per execution (1–15).
- i_CLOCK  in  1  system clock.
- i_RESET_N  in  1  reset; synchronous, active-low.
- i_TRIG  in  1  one-cycle key event pulse from the keypad input unit.
- i_KEY  in  4  key code, valid with `i_TRIG`: 0–9 digit, A add, B subtract, E equals, F clear entry; C/D reserved for game and ignored.
- i_ENTRY_VALID  in  1  current entry fits in 8-bit two's complement.
- i_GAME  in  1  game mode active; sequencer frozen.
- o_LOADA_N  out  1  active-low one-cycle strobe, load operand A.
- o_LOADB_N  out  1  active-low one-cycle strobe, load operand B.
- o_LOADR  out  1  high for EXEC_CYCLES cycles, AU result output enable.
- o_ADDSUB  out  1  0 add, 1 subtract; held.
- o_SRC_R  out  1  A-mux selects the AU result instead of the IU entry; coincident with `o_LOADA_N` low.
- o_CLR_ENTRY  out  1  one-cycle pulse, clears the IU entry.
- o_IUAU  out  1  display select: 0 IU entry, 1 AU result.
- o_ERR  out  1  error state indicator.
- o_DROP  out  1  one-cycle pulse: pending key overwritten.
- o_STATE  out  3  current state encoding.

## Operation
States:
- ENTER_A (0)
  - Digit: no action.
  - A/B: if valid, strobe A, latch `o_ADDSUB` (A→0, B→1), pulse clear, go to ENTER_B; if invalid, go to ERR.
  - F: pulse clear.
  - E: ignored.
- ENTER_B (1)
  - Digit: sets internal `digit_seen`.
  - A/B: replaces the operator only.
  - E with `digit_seen`=0: ignored.
  - E with `digit_seen`=1 and valid: strobe B, go to EXEC.
  - E with `digit_seen`=1 and invalid: go to ERR.
  - F: pulse clear, clear `digit_seen`.
- EXEC (2)
  - `o_LOADR` high for EXEC_CYCLES cycles.
  - Pulse clear on the last EXEC cycle.
  - Then go to SHOW.
  - Keys arriving during EXEC go to the pending buffer.
- SHOW (3)
  - `o_IUAU`=1.
  - Digit: `o_IUAU`←0, go to ENTER_A.
  - A/B: chain; strobe A with `o_SRC_R`=1, latch operator, pulse clear, go to ENTER_B.
  - E: ignored.
  - F: `o_IUAU`←0, pulse clear, go to ENTER_A.
- ERR (4)
  - `o_ERR`=1.
  - Only F exits: pulse clear, go to ENTER_A. All other keys are ignored.

Rules:
- `digit_seen` clears on entry to ENTER_B.
- Pending buffer:
  - One entry, filled by `i_TRIG` in EXEC.
  - A second key in EXEC overwrites the entry and pulses `o_DROP`.
  - The entry is consumed on the first SHOW cycle as if freshly triggered.
  - A live `i_TRIG` in that same cycle takes priority, the pending key is discarded, and `o_DROP` pulses.
- `i_GAME`=1:
  - `i_TRIG` is ignored.
  - State and counters hold.
  - Strobes are forced inactive (`o_LOADA_N`=`o_LOADB_N`=1, `o_LOADR`=0, `o_CLR_ENTRY`=0).
  - Held outputs are retained.
  - An EXEC in progress resumes counting when `i_GAME` returns low.

## Timing
- All outputs are registered.
- A key accepted at edge N produces its strobe/pulse at N+1 (one-cycle latency).
- `o_LOADA_N`/`o_LOADB_N` are low for exactly one cycle.
- `o_SRC_R` is high only in the `o_LOADA_N`-low cycle of a chain.
- EXEC entered at edge N: `o_LOADR` is high N+1..N+EXEC_CYCLES; `o_CLR_ENTRY` is high at N+EXEC_CYCLES; SHOW begins at N+EXEC_CYCLES+1.
- The operator latched in ENTER_B is stable on `o_ADDSUB` before, during and after `o_LOADR`.
- Reset (`i_RESET_N` low at an edge) overrides every event, including mid-EXEC. After the edge:
  - state ENTER_A;
  - `o_LOADA_N`=`o_LOADB_N`=1;
  - `o_LOADR`=`o_ADDSUB`=`o_SRC_R`=`o_CLR_ENTRY`=`o_IUAU`=`o_ERR`=`o_DROP`=0;
  - `o_STATE`=0;
  - pending buffer empty, EXEC counter 0, `digit_seen`=0.

## Structure
- Shared package `calc_pkg`:
  - state enum (ENTER_A..ERR, 3-bit);
  - key constants KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_EQ=4'hE, KEY_CE=4'hF;
  - operator encoding OP_ADD=0, OP_SUB=1.
- Sub-module `key_event_buffer`: one-entry pending register with write, consume and overwrite-detect (drives `o_DROP`).
- The FSM, EXEC counter (4-bit) and output registers live in the top level.

## Test plan
- Reset, then keys 5, A (valid), 3, E with EXEC_CYCLES=2 → `o_LOADA_N` low 1 cycle after A; `o_ADDSUB`=0; `o_CLR_ENTRY` pulse; `o_LOADB_N` low 1 cycle after E; `o_LOADR` high 2 cycles; `o_STATE`=3; `o_IUAU`=1.
- In ENTER_B, keys B then A, then digit, then E → `o_ADDSUB` ends at 0, no extra `o_LOADA_N` strobe; E without a digit beforehand produces no `o_LOADB_N`.
- In SHOW, key B → `o_LOADA_N` low with `o_SRC_R`=1 in the same cycle, `o_ADDSUB`=1, state ENTER_B.
- Op key with `i_ENTRY_VALID`=0 → `o_ERR`=1, state 4; keys A/E/5 ignored; F → `o_CLR_ENTRY` pulse, state 0, `o_ERR`=0.
- Two keys (7, then A) during EXEC → `o_DROP` pulse on the second; in the first SHOW cycle, A is processed as a chain.
- `i_GAME` raised mid-EXEC for 10 cycles → `o_LOADR` forced 0, counter holds; after release, the remaining `o_LOADR` cycles complete. `i_RESET_N` low mid-EXEC → all reset values next cycle.
